// File: rtl/circuit8_pkg.sv
// Shared constants and types for the Circuit_8 result capture path.
package circuit8_pkg;

    localparam int unsigned DATAWIDTH  = 64;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef logic [DATAWIDTH-1:0] circuit8_word_t;

endpackage

// File: rtl/circuit8_fifo_mem.sv
// Simple dual-port storage for the result FIFO: synchronous write, asynchronous read.
module circuit8_fifo_mem #(
    parameter int unsigned DATAWIDTH = 64,
    parameter int unsigned DEPTH     = 8,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/circuit8_result_fifo.sv
// First-word-fall-through result FIFO with sticky overflow flag.
// Optional push/drop statistics counters enabled by CIRCUIT8_FIFO_STATS_EN.
module circuit8_result_fifo
    import circuit8_pkg::*;
#(
    parameter int unsigned DATAWIDTH = circuit8_pkg::DATAWIDTH,
    parameter int unsigned DEPTH     = circuit8_pkg::FIFO_DEPTH,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
`ifdef CIRCUIT8_FIFO_STATS_EN
    ,
    output logic [31:0]          push_cnt,
    output logic [31:0]          drop_cnt
`endif
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic [DATAWIDTH-1:0] head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign out_valid = !empty;
    assign in_ready  = !full || out_ready;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && in_ready;
    assign drop      = in_valid && !in_ready;

    assign out_data = empty ? '0 : head;

    circuit8_fifo_mem #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef CIRCUIT8_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && (push_cnt != '1)) begin
                push_cnt <= push_cnt + 32'd1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_circuit8_result_fifo.sv
// Randomised scoreboard bench for circuit8_result_fifo against a queue-based reference model.
module tb_circuit8_result_fifo;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;
`ifdef CIRCUIT8_FIFO_STATS_EN
    logic [31:0]   push_cnt;
    logic [31:0]   drop_cnt;
`endif

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] model [$];
    logic [DW-1:0] got   [$];
    logic [DW-1:0] sent  [$];
    bit            exp_ovf  = 0;
    int            exp_push = 0;
    int            exp_drop = 0;
    bit            mon_en   = 0;

    circuit8_result_fifo #(
        .DATAWIDTH (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef CIRCUIT8_FIFO_STATS_EN
        ,
        .push_cnt  (push_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compares DUT against the model between edges, then advances the model
    always @(negedge clk) begin
        if (rst && mon_en) begin : mon
            int n;
            bit rdy;
            n   = model.size();
            rdy = (n < DEPTH) || out_ready;
            chk("count", 64'(count), 64'(n));
            chk("full", 64'(full), 64'(n == DEPTH));
            chk("empty", 64'(empty), 64'(n == 0));
            chk("out_valid", 64'(out_valid), 64'(n != 0));
            chk("out_data", out_data, (n != 0) ? model[0] : 64'd0);
            chk("in_ready", 64'(in_ready), 64'(rdy));
            chk("overflow", 64'(overflow), 64'(exp_ovf));
`ifdef CIRCUIT8_FIFO_STATS_EN
            chk("push_cnt", 64'(push_cnt), 64'(exp_push));
            chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
`endif
            if (n != 0 && out_ready) begin
                got.push_back(out_data);
                void'(model.pop_front());
            end
            if (in_valid) begin
                if (rdy) begin
                    model.push_back(in_data);
                    exp_push++;
                end else begin
                    exp_ovf = 1;
                    exp_drop++;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        in_valid = 1;
        in_data  = w;
        cycle();
        in_valid = 0;
    endtask

    // Called just after an edge with in_valid low; reset lands between edges.
    task automatic rst_pulse();
        in_valid = 0;
        #1 rst = 0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        model.delete();
        got.delete();
        exp_ovf  = 0;
        exp_push = 0;
        exp_drop = 0;
        #1 rst = 1;
    endtask

    task automatic drain();
        int k;
        out_ready = 1;
        k = 0;
        while (model.size() != 0 && k < 100) begin
            cycle();
            k++;
        end
        if (model.size() != 0) chk("drain_timeout", 64'(model.size()), 64'd0);
        cycle();
        out_ready = 0;
    endtask

    initial begin
        logic [DW-1:0] basic [4];
        int idx;
        int k;
        basic = '{64'd16, 64'd255, 64'd21, 64'd116};
        rst = 0; in_valid = 0; in_data = '0; out_ready = 0;

        #3;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_overflow", 64'(overflow), 64'd0);
`ifdef CIRCUIT8_FIFO_STATS_EN
        chk("reset_push_cnt", 64'(push_cnt), 64'd0);
        chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        #9 rst = 1;
        mon_en = 1;
        cycle();

        // Reset in the middle of operation
        for (int i = 0; i < 3; i++) push_word({$urandom, $urandom});
        rst_pulse();
        cycle();

        // Basic ordering
        foreach (basic[i]) push_word(basic[i]);
        cycle();
        chk("basic_count", 64'(count), 64'd4);
        drain();
        chk("basic_num", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("basic_order", got[i], basic[i]);
        chk("basic_empty", 64'(empty), 64'd1);

        // Fill to full and overflow by one
        rst_pulse();
        cycle();
        for (int i = 1; i <= 9; i++) push_word(64'(i));
        cycle();
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_overflow", 64'(overflow), 64'd1);
`ifdef CIRCUIT8_FIFO_STATS_EN
        chk("fill_push_cnt", 64'(push_cnt), 64'd8);
        chk("fill_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

        // Simultaneous push and pop while full
        in_valid = 1; in_data = 64'd99; out_ready = 1;
        cycle();
        in_valid = 0; out_ready = 0;
        cycle();
        chk("simul_count", 64'(count), 64'd8);
        chk("simul_overflow", 64'(overflow), 64'd1);
        drain();
        chk("simul_num", 64'(got.size()), 64'd9);
        for (int i = 0; i < 8; i++) chk("simul_order", got[i], 64'(i + 1));
        chk("simul_last", got[got.size() - 1], 64'd99);

        // Wrap-around streaming with a half-rate consumer
        rst_pulse();
        cycle();
        sent.delete();
        idx = 0;
        k = 0;
        while (idx < 20 && k < 200) begin
            out_ready = k[0];
            #1;
            if (in_ready) begin
                in_valid = 1;
                in_data  = {$urandom, $urandom};
                sent.push_back(in_data);
                idx++;
            end else begin
                in_valid = 0;
            end
            cycle();
            k++;
        end
        in_valid = 0;
        if (idx != 20) chk("wrap_timeout", 64'(idx), 64'd20);
        drain();
        chk("wrap_num", 64'(got.size()), 64'd20);
        for (int i = 0; i < 20; i++) chk("wrap_order", got[i], sent[i]);
        chk("wrap_overflow", 64'(overflow), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        in_valid = 0;
        drain();

        mon_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
